// File: rtl/xsm_pkg.sv
// Shared types and constants for the XSM capture scheduler.
package xsm_pkg;

    localparam int XSM_NUM_CH      = 4;
    localparam int XSM_CH_W        = 2;
    localparam int XSM_PERIOD_W    = 16;
    localparam int XSM_TIMEOUT_CYC = 64;

    typedef enum logic [1:0] {
        MODE_SINGLE   = 2'b00,
        MODE_PERIODIC = 2'b01,
        MODE_EXT      = 2'b10,
        MODE_RSVD     = 2'b11
    } xsm_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } xsm_sched_state_e;

    localparam logic [XSM_CH_W-1:0] CH_VIN  = 2'd0;
    localparam logic [XSM_CH_W-1:0] CH_VOUT = 2'd1;
    localparam logic [XSM_CH_W-1:0] CH_IOUT = 2'd2;
    localparam logic [XSM_CH_W-1:0] CH_TEMP = 2'd3;

endpackage

// File: rtl/xsm_ch_pick.sv
// Next-channel finder: next set mask bit above cur, or lowest set bit when first=1.
// Latency: combinational.
// Backpressure: none.
module xsm_ch_pick
    import xsm_pkg::*;
#(
    parameter int NUM_CH = XSM_NUM_CH,
    parameter int CH_W   = XSM_CH_W
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   cur,
    input  logic              first,
    output logic [CH_W-1:0]   nxt,
    output logic              nxt_vld
);

    // Scan high to low so the last hit left standing is the lowest qualifying bit.
    always_comb begin
        nxt     = '0;
        nxt_vld = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (first || (i > int'(cur)))) begin
                nxt     = CH_W'(i);
                nxt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xsm_capture_sched.sv
// Capture sequencer: sweeps enabled channels, one request then wait for sample per channel.
// Latency: cap_req one cycle after the start event; min sweep 2*popcount(mask)+1 cycles.
// Backpressure: starts while busy are dropped and flagged; a silent channel is abandoned after TIMEOUT_CYC.
module xsm_capture_sched
    import xsm_pkg::*;
#(
    parameter int NUM_CH      = XSM_NUM_CH,
    parameter int CH_W        = XSM_CH_W,
    parameter int PERIOD_W    = XSM_PERIOD_W,
    parameter int TIMEOUT_CYC = XSM_TIMEOUT_CYC
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_en,
    input  logic [1:0]          cfg_mode,
    input  logic [NUM_CH-1:0]   cfg_ch_mask,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic                start,
    input  logic                ext_trig,
    input  logic                err_clr,
    output logic                cap_req,
    output logic [CH_W-1:0]     cap_ch,
    input  logic                cap_done,
    output logic                busy,
    output logic                sweep_done,
    output logic [15:0]         sweep_cnt,
    output logic                timeout_err,
    output logic                overrun_err
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_REQ  = ST_REQ;
    localparam logic [1:0] S_WAIT = ST_WAIT;
    localparam logic [1:0] S_DONE = ST_DONE;

    localparam int            TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [1:0]          state;
    logic [NUM_CH-1:0]   mask_q;
    logic [CH_W-1:0]     ch_q;
    logic [TO_W-1:0]     tcnt;
    logic [PERIOD_W-1:0] pcnt;
    logic                trig_q;
    logic [15:0]         sweep_cnt_q;
    logic                timeout_q;
    logic                overrun_q;

    logic                period_run;
    logic [PERIOD_W-1:0] period_last;
    logic                period_tick;
    logic                start_evt;
    logic                busy_i;
    logic                wait_exit;
    logic                to_set;
    logic                pick_first;
    logic [NUM_CH-1:0]   pick_mask;
    logic [CH_W-1:0]     pick_ch;
    logic                pick_vld;

    // A zero period behaves as one: tick every cycle.
    assign period_run  = cfg_en && (cfg_mode == MODE_PERIODIC);
    assign period_last = (cfg_period == '0) ? '0 : cfg_period - 1'b1;
    assign period_tick = period_run && (pcnt == period_last);

    assign start_evt = cfg_en && (((cfg_mode == MODE_SINGLE) && start) ||
                                  period_tick ||
                                  ((cfg_mode == MODE_EXT) && ext_trig && !trig_q));

    assign busy_i    = (state != S_IDLE);
    assign wait_exit = (state == S_WAIT) && (cap_done || (tcnt == TO_LAST));
    assign to_set    = cfg_en && (state == S_WAIT) && !cap_done && (tcnt == TO_LAST);

    // In IDLE the live mask seeds the sweep; afterwards only the latched copy matters.
    assign pick_first = (state == S_IDLE);
    assign pick_mask  = pick_first ? cfg_ch_mask : mask_q;

    xsm_ch_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_ch_pick (
        .mask    (pick_mask),
        .cur     (ch_q),
        .first   (pick_first),
        .nxt     (pick_ch),
        .nxt_vld (pick_vld)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            mask_q      <= '0;
            ch_q        <= '0;
            tcnt        <= '0;
            pcnt        <= '0;
            trig_q      <= 1'b0;
            sweep_cnt_q <= '0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            trig_q <= ext_trig;

            if (!period_run || period_tick) pcnt <= '0;
            else                            pcnt <= pcnt + 1'b1;

            if (start_evt && busy_i) overrun_q <= 1'b1;
            else if (err_clr)        overrun_q <= 1'b0;

            if (to_set)       timeout_q <= 1'b1;
            else if (err_clr) timeout_q <= 1'b0;

            if (!cfg_en) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_evt && pick_vld) begin
                            mask_q <= cfg_ch_mask;
                            ch_q   <= pick_ch;
                            state  <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        tcnt  <= '0;
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (wait_exit) begin
                            if (pick_vld) begin
                                ch_q  <= pick_ch;
                                state <= S_REQ;
                            end else begin
                                state <= S_DONE;
                            end
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                    S_DONE: begin
                        sweep_cnt_q <= sweep_cnt_q + 16'd1;
                        state       <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign cap_req     = cfg_en && (state == S_REQ);
    assign sweep_done  = cfg_en && (state == S_DONE);
    assign cap_ch      = ch_q;
    assign busy        = busy_i;
    assign sweep_cnt   = sweep_cnt_q;
    assign timeout_err = timeout_q;
    assign overrun_err = overrun_q;

endmodule

// File: tb/tb_xsm_capture_sched.sv
// Randomized scoreboard bench for xsm_capture_sched: expected channel order, sweep
// length and sweep count are derived from the mask and responder delays.
module tb_xsm_capture_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_en;
    logic [1:0]  cfg_mode;
    logic [3:0]  cfg_ch_mask;
    logic [15:0] cfg_period;
    logic        start;
    logic        ext_trig;
    logic        err_clr;
    logic        cap_req;
    logic [1:0]  cap_ch;
    logic        cap_done;
    logic        busy;
    logic        sweep_done;
    logic [15:0] sweep_cnt;
    logic        timeout_err;
    logic        overrun_err;

    xsm_capture_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_en      (cfg_en),
        .cfg_mode    (cfg_mode),
        .cfg_ch_mask (cfg_ch_mask),
        .cfg_period  (cfg_period),
        .start       (start),
        .ext_trig    (ext_trig),
        .err_clr     (err_clr),
        .cap_req     (cap_req),
        .cap_ch      (cap_ch),
        .cap_done    (cap_done),
        .busy        (busy),
        .sweep_done  (sweep_done),
        .sweep_cnt   (sweep_cnt),
        .timeout_err (timeout_err),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int cnt;
    } sw_t;

    int  n_pass  = 0;
    int  n_total = 0;
    int  exp_ch[$];
    sw_t exp_sw[$];
    sw_t mon_e;
    int  req0_cyc[$];
    int  resp_dly[4];
    int  model_cnt = 0;
    int  cyc = 0;
    int  run = 0;
    int  pend_cnt = -1;
    bit  sb_on = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic fail(input string name, input int act);
        n_total++;
        $display("FAIL %s: got %0d expected nothing", name, act);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: channels in ascending mask order; each channel costs one
    // request cycle plus its wait (delay+1, or the full 64-cycle timeout), plus one DONE.
    task automatic expect_sweep(input logic [3:0] m);
        int len = 1;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                exp_ch.push_back(i);
                len += (resp_dly[i] < 0) ? 65 : resp_dly[i] + 2;
            end
        end
        model_cnt = (model_cnt + 1) % 65536;
        exp_sw.push_back('{len, model_cnt});
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        while (busy && k < limit) begin
            tick(1);
            k++;
        end
        chk("idle_within_budget", int'(busy), 0);
    endtask

    task automatic run_single(input logic [3:0] m, input bit scramble);
        cfg_ch_mask = m;
        expect_sweep(m);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        if (scramble) cfg_ch_mask = 4'($urandom);
        wait_idle(400);
        tick(1);
    endtask

    // Capture datapath stand-in: answers each request after resp_dly[ch] WAIT cycles.
    initial begin
        int d;
        cap_done = 1'b0;
        forever begin
            @(negedge clk);
            if (cap_req) begin
                d = resp_dly[cap_ch];
                if (d >= 0) begin
                    @(posedge clk);
                    repeat (d) @(posedge clk);
                    #1 cap_done = 1'b1;
                    @(posedge clk);
                    #1 cap_done = 1'b0;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a request or sweep end.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (pend_cnt >= 0) begin
                chk("sweep_cnt_after_done", int'(sweep_cnt), pend_cnt);
                pend_cnt = -1;
            end
            if (busy) run++;
            if (cap_req) begin
                if (cap_ch == 2'd0) req0_cyc.push_back(cyc);
                if (sb_on) begin
                    if (exp_ch.size() == 0) fail("unexpected_cap_req", int'(cap_ch));
                    else chk("cap_ch_order", int'(cap_ch), exp_ch.pop_front());
                end
            end
            if (sweep_done && sb_on) begin
                if (exp_sw.size() == 0) begin
                    fail("unexpected_sweep_done", run);
                end else begin
                    mon_e = exp_sw.pop_front();
                    chk("sweep_len", run, mon_e.len);
                    pend_cnt = mon_e.cnt;
                end
            end
            if (!busy) run = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst_n = 1'b0; cfg_en = 1'b0; cfg_mode = 2'b00; cfg_ch_mask = 4'b0;
        cfg_period = 16'd0; start = 1'b0; ext_trig = 1'b0; err_clr = 1'b0;
        for (int i = 0; i < 4; i++) resp_dly[i] = 1;
        tick(3);
        chk("rst_cap_req", int'(cap_req), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sweep_done", int'(sweep_done), 0);
        chk("rst_sweep_cnt", int'(sweep_cnt), 0);
        chk("rst_errs", int'({timeout_err, overrun_err}), 0);
        chk("rst_cap_ch", int'(cap_ch), 0);
        rst_n = 1'b1;
        cfg_en = 1'b1;
        tick(2);

        // Full mask, single start: check request latency explicitly.
        cfg_ch_mask = 4'b1111;
        expect_sweep(4'b1111);
        start = 1'b1;
        chk("req_before_edge", int'(cap_req), 0);
        tick(1);
        start = 1'b0;
        chk("req_after_edge", int'(cap_req), 1);
        chk("first_ch", int'(cap_ch), 0);
        wait_idle(200);
        tick(1);
        chk("cnt_after_first", int'(sweep_cnt), 1);

        // Sparse mask, immediate done: minimum-length sweep.
        for (int i = 0; i < 4; i++) resp_dly[i] = 0;
        run_single(4'b1010, 1'b0);

        // Zero mask: start ignored.
        cfg_ch_mask = 4'b0000;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        k = 0;
        repeat (5) begin
            if (busy || cap_req) k++;
            tick(1);
        end
        chk("zero_mask_no_sweep", k, 0);
        chk("zero_mask_no_overrun", int'(overrun_err), 0);

        // Random masks and delays, mask scrambled mid-sweep.
        repeat (12) begin
            for (int i = 0; i < 4; i++) resp_dly[i] = $urandom_range(0, 4);
            run_single(4'($urandom_range(1, 15)), 1'b1);
            tick($urandom_range(1, 3));
        end
        chk("cnt_after_random", int'(sweep_cnt), model_cnt);

        // Timeout on ch2, others answer.
        resp_dly[0] = 1; resp_dly[1] = 1; resp_dly[2] = -1; resp_dly[3] = 1;
        run_single(4'b1111, 1'b0);
        chk("timeout_set", int'(timeout_err), 1);
        chk("timeout_no_overrun", int'(overrun_err), 0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("timeout_cleared", int'(timeout_err), 0);

        // Periodic mode, period 20: three sweeps, ch0 requests 20 cycles apart.
        for (int i = 0; i < 4; i++) resp_dly[i] = 0;
        cfg_ch_mask = 4'b1111;
        cfg_period = 16'd20;
        req0_cyc.delete();
        repeat (3) expect_sweep(4'b1111);
        cfg_mode = 2'b01;
        k = 0;
        while (exp_sw.size() != 0 && k < 300) begin
            tick(1);
            k++;
        end
        chk("periodic_sweeps_seen", exp_sw.size(), 0);
        cfg_mode = 2'b00;
        wait_idle(50);
        tick(1);
        if (req0_cyc.size() >= 3) begin
            chk("period_gap1", req0_cyc[1] - req0_cyc[0], 20);
            chk("period_gap2", req0_cyc[2] - req0_cyc[1], 20);
        end else begin
            fail("periodic_req0_count", req0_cyc.size());
        end
        chk("periodic_no_overrun", int'(overrun_err), 0);

        // External trigger held high: one sweep only.
        cfg_mode = 2'b10;
        expect_sweep(4'b1111);
        ext_trig = 1'b1;
        tick(10);
        ext_trig = 1'b0;
        wait_idle(50);
        tick(2);
        chk("ext_one_sweep_cnt", int'(sweep_cnt), model_cnt);
        chk("ext_no_overrun", int'(overrun_err), 0);

        // Second edge mid-sweep: overrun, still exactly one sweep.
        for (int i = 0; i < 4; i++) resp_dly[i] = 3;
        expect_sweep(4'b1111);
        ext_trig = 1'b1;
        tick(2);
        ext_trig = 1'b0;
        tick(2);
        ext_trig = 1'b1;
        tick(1);
        ext_trig = 1'b0;
        wait_idle(100);
        tick(2);
        chk("ext_overrun", int'(overrun_err), 1);
        chk("ext_overrun_cnt", int'(sweep_cnt), model_cnt);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("overrun_cleared", int'(overrun_err), 0);

        // cfg_en dropped while waiting on ch1.
        cfg_mode = 2'b00;
        resp_dly[0] = 1; resp_dly[1] = -1; resp_dly[2] = 1; resp_dly[3] = 1;
        cfg_ch_mask = 4'b1111;
        exp_ch.push_back(0);
        exp_ch.push_back(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        k = 0;
        while (!(busy && !cap_req && cap_ch == 2'd1) && k < 50) begin
            tick(1);
            k++;
        end
        chk("reached_wait_ch1", int'(busy && !cap_req && cap_ch == 2'd1), 1);
        cfg_en = 1'b0;
        chk("en_low_no_req", int'(cap_req), 0);
        tick(1);
        chk("en_low_idle", int'(busy), 0);
        chk("en_low_no_done", int'(sweep_done), 0);
        chk("en_low_cnt_kept", int'(sweep_cnt), model_cnt);
        cfg_en = 1'b1;
        tick(2);
        chk("en_drop_queue_drained", exp_ch.size(), 0);

        // Period shorter than the sweep: overrun.
        sb_on = 1'b0;
        for (int i = 0; i < 4; i++) resp_dly[i] = 0;
        cfg_period = 16'd4;
        cfg_mode = 2'b01;
        tick(40);
        cfg_mode = 2'b00;
        wait_idle(50);
        chk("short_period_overrun", int'(overrun_err), 1);

        // Reset mid-sweep.
        for (int i = 0; i < 4; i++) resp_dly[i] = 2;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        rst_n = 1'b0;
        tick(1);
        chk("midrst_cap_req", int'(cap_req), 0);
        chk("midrst_cap_ch", int'(cap_ch), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_sweep_done", int'(sweep_done), 0);
        chk("midrst_sweep_cnt", int'(sweep_cnt), 0);
        chk("midrst_errs", int'({timeout_err, overrun_err}), 0);
        rst_n = 1'b1;
        tick(10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
